// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the registered priority encoder.
package prio_enc_pkg;

  // Default number of request inputs.
  localparam int PRIO_N_DEFAULT = 4;

  // Output registers return to these values under reset.
  localparam int   Y_RST = 0;
  localparam logic Z_RST = 1'b0;

  // Index width needed to address n request bits.
  function automatic int prio_yw(input int n);
    return $clog2(n);
  endfunction

endpackage : prio_enc_pkg

// File: rtl/prio_enc_core.sv
// Combinational N-to-YW priority encoder: highest asserted index wins.
module prio_enc_core
  import prio_enc_pkg::*;
#(
  parameter int N  = PRIO_N_DEFAULT,
  parameter int YW = prio_yw(N)
) (
  input  logic [N-1:0]  w,
  output logic [YW-1:0] y_nxt,
  output logic          z_nxt
);

  logic found;

  // Scan from the top index down; the first set bit found is the answer,
  // so lower bits are ignored once a higher one is set. No hit leaves y at 0.
  always_comb begin
    y_nxt = '0;
    z_nxt = |w;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!found && w[i]) begin
        y_nxt = YW'(i);
        found = 1'b1;
      end
    end
  end

endmodule : prio_enc_core

// File: rtl/priority_encoder_4x2.sv
// Registered priority encoder with valid flag and update enable.
// Outputs come straight from flops; reset clears them asynchronously.
module priority_encoder_4x2
  import prio_enc_pkg::*;
#(
  parameter int N  = PRIO_N_DEFAULT,
  parameter int YW = prio_yw(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [N-1:0]  w,
  output logic [YW-1:0] y,
  output logic          z
);

  // Reject configurations that cannot encode every request index.
  if (N < 2 || YW < $clog2(N)) begin : g_param_check
    $error("priority_encoder_4x2: need N >= 2 and YW >= $clog2(N)");
  end

  logic [YW-1:0] y_enc;
  logic          z_enc;
  logic [YW-1:0] y_d, y_q;
  logic          z_d, z_q;

  prio_enc_core #(
    .N  (N),
    .YW (YW)
  ) u_core (
    .w     (w),
    .y_nxt (y_enc),
    .z_nxt (z_enc)
  );

  // Load the freshly encoded value when enabled, otherwise hold.
  always_comb begin
    y_d = y_q;
    z_d = z_q;
    if (en) begin
      y_d = y_enc;
      z_d = z_enc;
    end
  end

  // Output register; reset takes effect immediately and wins over the clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= YW'(Y_RST);
      z_q <= Z_RST;
    end else begin
      y_q <= y_d;
      z_q <= z_d;
    end
  end

  assign y = y_q;
  assign z = z_q;

endmodule : priority_encoder_4x2

// File: tb/tb_priority_encoder_4x2.sv
// Directed bench for priority_encoder_4x2 with a queue-based scoreboard.
`timescale 1ns/1ps
module tb_priority_encoder_4x2;

  typedef struct packed {
    logic [1:0] y;
    logic       z;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] w;
  logic [1:0] y;
  logic       z;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];
  exp_t model;

  priority_encoder_4x2 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .w     (w),
    .y     (y),
    .z     (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference priority function written as an explicit if-chain.
  function automatic exp_t ref_enc(input logic [3:0] wv);
    exp_t e;
    e.z = (wv != 4'b0000);
    if (wv[3])      e.y = 2'd3;
    else if (wv[2]) e.y = 2'd2;
    else if (wv[1]) e.y = 2'd1;
    else            e.y = 2'd0;
    return e;
  endfunction

  task automatic check(input string tag, input exp_t exp_v);
    checks++;
    assert ({y, z} === {exp_v.y, exp_v.z})
    else begin
      errors++;
      $error("FAIL %s observed y=%0d z=%0b expected y=%0d z=%0b",
             tag, y, z, exp_v.y, exp_v.z);
    end
  endtask

  // Drive one cycle of stimulus, push the expectation, compare after the edge.
  task automatic step(input string tag, input logic [3:0] wv, input logic env);
    exp_t got_exp;
    @(negedge clk);
    w  = wv;
    en = env;
    if (env) model = ref_enc(wv);
    sb_q.push_back(model);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed empty scoreboard expected one entry", tag);
    end else begin
      got_exp = sb_q.pop_front();
      check(tag, got_exp);
    end
    $display("step %-10s w=%b en=%b -> y=%0d z=%0b", tag, wv, env, y, z);
  endtask

  initial begin
    exp_t zero_e;
    zero_e = '{y: 2'd0, z: 1'b0};
    model  = zero_e;

    // Reset held with all requests active and enable high.
    rst_n = 1'b0;
    en    = 1'b1;
    w     = 4'b1111;
    #1;
    check("rst_init", zero_e);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("rst_hold", zero_e);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Top priority bit with random lower bits.
    for (int i = 0; i < 20; i++)
      step("top", {1'b1, 3'($urandom_range(0, 7))}, 1'b1);

    // Second priority with random lower bits.
    for (int i = 0; i < 20; i++)
      step("second", {2'b01, 2'($urandom_range(0, 3))}, 1'b1);

    // Low bits and the all-zero case.
    step("low1", 4'b0010, 1'b1);
    step("low0", 4'b0001, 1'b1);
    step("none", 4'b0000, 1'b1);

    // Enable hold: capture 3, ignore w while en is low, then reload.
    step("cap3", 4'b1000, 1'b1);
    for (int i = 0; i < 3; i++)
      step("hold", 4'b0001, 1'b0);
    step("reload", 4'b0001, 1'b1);

    // Async reset injected between clock edges, with a value captured.
    step("cap2", 4'b0100, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async", zero_e);
    #1;
    rst_n = 1'b1;
    model = zero_e;
    #0.5;
    check("rst_release", zero_e);
    step("post_rst", 4'b0010, 1'b1);
    step("post_rst2", 4'b1001, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_priority_encoder_4x2
